lsu: RTL and testbench

- Load/store unit sitting directly upstream of the main memory block `mm`, between the CPU execute stage and the memory.
- Accepts one load/store request at a time and issues the correctly sized memory write.
- Waits out the memory's one-cycle registered read latency, then returns the extracted, sign- or zero-extended load data.
- Rejects misaligned or out-of-range accesses without touching memory.

---
 rtl/lsu_pkg.sv | 48 ++++
 rtl/lsu_extract.sv | 30 +++
 rtl/lsu.sv | 126 ++++++++++++
 tb/tb_lsu.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: opcodes, FSM states, mm write codes
// and small decode helpers.
package lsu_pkg;

    typedef enum logic [2:0] {
        LSU_LB  = 3'd0,
        LSU_LBU = 3'd1,
        LSU_LH  = 3'd2,
        LSU_LHU = 3'd3,
        LSU_LW  = 3'd4,
        LSU_SB  = 3'd5,
        LSU_SH  = 3'd6,
        LSU_SW  = 3'd7
    } lsu_op_e;

    typedef enum logic [1:0] {
        LSU_S_IDLE    = 2'd0,
        LSU_S_ISSUE   = 2'd1,
        LSU_S_CAPTURE = 2'd2
    } lsu_state_e;

    localparam logic [1:0] MM_WR_NONE = 2'd0;
    localparam logic [1:0] MM_WR_B    = 2'd1;
    localparam logic [1:0] MM_WR_HW   = 2'd2;
    localparam logic [1:0] MM_WR_W    = 2'd3;

    function automatic logic is_store(lsu_op_e op);
        return (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
    endfunction

    function automatic logic [2:0] access_size(lsu_op_e op);
        case (op)
            LSU_LB, LSU_LBU, LSU_SB: return 3'd1;
            LSU_LH, LSU_LHU, LSU_SH: return 3'd2;
            default:                 return 3'd4;
        endcase
    endfunction

    function automatic logic [1:0] wr_code(lsu_op_e op);
        case (op)
            LSU_SB:  return MM_WR_B;
            LSU_SH:  return MM_WR_HW;
            LSU_SW:  return MM_WR_W;
            default: return MM_WR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/lsu_extract.sv
// Combinational load-data formatter: reorders the mm read word (lowest address in
// the top byte) into a little-endian value and sign/zero extends per opcode.
module lsu_extract
    import lsu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] data,
    output logic [31:0] result
);

    logic [7:0] b0, b1, b2, b3;

    assign b0 = data[31:24];
    assign b1 = data[23:16];
    assign b2 = data[15:8];
    assign b3 = data[7:0];

    always_comb begin
        result = '0;
        case (lsu_op_e'(op))
            LSU_LB:  result = {{24{b0[7]}}, b0};
            LSU_LBU: result = {24'd0, b0};
            LSU_LH:  result = {{16{b1[7]}}, b1, b0};
            LSU_LHU: result = {16'd0, b1, b0};
            LSU_LW:  result = {b3, b2, b1, b0};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit in front of main memory: one request at a time, sized stores,
// registered-latency loads, and fault reporting for misaligned/out-of-range access.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 256
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ,
    input  logic [2:0]  OP,
    input  logic [31:0] ADDR,
    input  logic [31:0] WDATA,
    output logic        BUSY,
    output logic        DONE,
    output logic        FAULT,
    output logic [31:0] RDATA,
    output logic [31:0] MM_ADDR,
    output logic [1:0]  MM_WR,
    output logic [31:0] MM_D_IN,
    input  logic [31:0] MM_D_OUT
);

    lsu_state_e  state_q, state_d;
    lsu_op_e     op_q, op_d;
    logic        busy_q, done_q, done_d, fault_q, fault_d;
    logic [31:0] rdata_q, rdata_d, addr_q, addr_d, din_q, din_d;
    logic [1:0]  wr_q, wr_d;

    lsu_op_e     op_in;
    logic [2:0]  size_in;
    logic [32:0] last_byte;
    logic        misaligned, out_of_range;
    logic [31:0] load_result;

    assign op_in   = lsu_op_e'(OP);
    assign size_in = access_size(op_in);

    // 33-bit sum so addresses near 2^32 cannot wrap back into range.
    assign last_byte    = {1'b0, ADDR} + {30'd0, size_in} - 33'd1;
    assign out_of_range = last_byte > 33'(MEM_BYTES - 1);
    assign misaligned   = ((size_in == 3'd2) && ADDR[0]) ||
                          ((size_in == 3'd4) && (ADDR[1:0] != 2'b00));

    lsu_extract u_extract (
        .op     (op_q),
        .data   (MM_D_OUT),
        .result (load_result)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        din_d   = din_q;
        rdata_d = rdata_q;
        wr_d    = MM_WR_NONE;
        done_d  = 1'b0;
        fault_d = 1'b0;
        case (state_q)
            LSU_S_IDLE: begin
                if (REQ) begin
                    if (misaligned || out_of_range) begin
                        done_d  = 1'b1;
                        fault_d = 1'b1;
                    end else begin
                        addr_d  = ADDR;
                        op_d    = op_in;
                        state_d = LSU_S_ISSUE;
                        if (is_store(op_in)) begin
                            din_d = WDATA;
                            wr_d  = wr_code(op_in);
                        end
                    end
                end
            end
            LSU_S_ISSUE: begin
                if (is_store(op_q)) begin
                    done_d  = 1'b1;
                    state_d = LSU_S_IDLE;
                end else begin
                    state_d = LSU_S_CAPTURE;
                end
            end
            LSU_S_CAPTURE: begin
                rdata_d = load_result;
                done_d  = 1'b1;
                state_d = LSU_S_IDLE;
            end
            default: state_d = LSU_S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= LSU_S_IDLE;
            op_q    <= LSU_LB;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            rdata_q <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            wr_q    <= MM_WR_NONE;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            busy_q  <= (state_d != LSU_S_IDLE);
            done_q  <= done_d;
            fault_q <= fault_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            wr_q    <= wr_d;
        end
    end

    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign FAULT   = fault_q;
    assign RDATA   = rdata_q;
    assign MM_ADDR = addr_q;
    assign MM_WR   = wr_q;
    assign MM_D_IN = din_q;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: a byte-array reference model predicts each completion,
// a monitor compares every DONE against the queued expectation.
module tb_lsu;
    import lsu_pkg::*;

    localparam int unsigned MEM_BYTES = 256;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        REQ = 1'b0;
    logic [2:0]  OP = 3'd0;
    logic [31:0] ADDR = '0, WDATA = '0;
    logic        BUSY, DONE, FAULT;
    logic [31:0] RDATA, MM_ADDR, MM_D_IN;
    logic [1:0]  MM_WR;
    logic [31:0] mm_d_out = '0;

    lsu #(.MEM_BYTES(MEM_BYTES)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .OP(OP), .ADDR(ADDR), .WDATA(WDATA),
        .BUSY(BUSY), .DONE(DONE), .FAULT(FAULT), .RDATA(RDATA),
        .MM_ADDR(MM_ADDR), .MM_WR(MM_WR), .MM_D_IN(MM_D_IN), .MM_D_OUT(mm_d_out)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        fault;
        logic [31:0] rdata;
        int unsigned issue;
        int unsigned lat;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned wr_seen = 0;
    int unsigned wr_exp = 0;
    logic [7:0]  mem[MEM_BYTES];
    logic [7:0]  ref_mem[MEM_BYTES];
    logic [31:0] model_rdata = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory device: byte-addressed, registered read, lowest address in the top byte.
    always @(posedge CLK) begin
        logic [7:0] a;
        a = MM_ADDR[7:0];
        cyc++;
        case (MM_WR)
            MM_WR_B: mem[a] <= MM_D_IN[7:0];
            MM_WR_HW: begin
                mem[a] <= MM_D_IN[7:0];
                mem[a+8'd1] <= MM_D_IN[15:8];
            end
            MM_WR_W: begin
                mem[a] <= MM_D_IN[7:0];
                mem[a+8'd1] <= MM_D_IN[15:8];
                mem[a+8'd2] <= MM_D_IN[23:16];
                mem[a+8'd3] <= MM_D_IN[31:24];
            end
            default: ;
        endcase
        if (MM_WR != MM_WR_NONE) wr_seen++;
        mm_d_out <= {mem[a], mem[a+8'd1], mem[a+8'd2], mem[a+8'd3]};
    end

    // Monitor: every DONE pops one expectation.
    always @(negedge CLK) begin
        exp_t e;
        if (!RST && DONE) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("fault", {31'd0, FAULT}, {31'd0, e.fault});
                chk("rdata", RDATA, e.rdata);
                chk("latency", cyc - e.issue, e.lat);
            end
        end
    end

    function automatic int unsigned op_size(input logic [2:0] op);
        if (op == LSU_LB || op == LSU_LBU || op == LSU_SB) return 1;
        if (op == LSU_LH || op == LSU_LHU || op == LSU_SH) return 2;
        return 4;
    endfunction

    function automatic logic op_is_store(input logic [2:0] op);
        return op == LSU_SB || op == LSU_SH || op == LSU_SW;
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata);
        exp_t        e;
        int unsigned sz;
        logic        flt;
        longint      v;
        logic [1:0]  code;
        sz  = op_size(op);
        flt = (addr % sz != 0) || (longint'(addr) + longint'(sz) - 1 > longint'(MEM_BYTES) - 1);
        e.fault = flt;
        e.issue = cyc;
        if (flt) begin
            e.lat = 1;
        end else if (op_is_store(op)) begin
            e.lat = 2;
            wr_exp++;
            for (int i = 0; i < int'(sz); i++) ref_mem[addr + i] = wdata[8*i +: 8];
        end else begin
            e.lat = 3;
            v = 0;
            for (int i = 0; i < int'(sz); i++) v = v + (longint'(ref_mem[addr + i]) << (8 * i));
            if ((op == LSU_LB || op == LSU_LH) && v >= (longint'(1) << (8 * sz - 1)))
                v = v - (longint'(1) << (8 * sz));
            model_rdata = v[31:0];
        end
        e.rdata = model_rdata;
        sb_q.push_back(e);
        REQ = 1'b1; OP = op; ADDR = addr; WDATA = wdata;
        @(posedge CLK); #1;
        REQ = 1'b0;
        if (!flt && op_is_store(op)) begin
            code = (sz == 1) ? MM_WR_B : (sz == 2) ? MM_WR_HW : MM_WR_W;
            chk("mm_wr_code", {30'd0, MM_WR}, {30'd0, code});
            chk("mm_addr", MM_ADDR, addr);
            chk("mm_d_in", MM_D_IN, wdata);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!DONE && n < 10) begin
            @(posedge CLK); #1;
            n++;
        end
        if (!DONE) chk("done_timeout", 32'd0, 32'd1);
        else begin
            chk("busy_at_done", {31'd0, BUSY}, 32'd0);
            chk("mm_wr_at_done", {30'd0, MM_WR}, {30'd0, MM_WR_NONE});
        end
    endtask

    task automatic preload(input int a, input logic [7:0] b);
        mem[a] = b;
        ref_mem[a] = b;
    endtask

    initial begin
        for (int i = 0; i < int'(MEM_BYTES); i++) begin
            mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        #1;
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_done", {31'd0, DONE}, 32'd0);
        chk("rst_fault", {31'd0, FAULT}, 32'd0);
        chk("rst_rdata", RDATA, 32'd0);
        chk("rst_mm_addr", MM_ADDR, 32'd0);
        chk("rst_mm_d_in", MM_D_IN, 32'd0);
        chk("rst_mm_wr", {30'd0, MM_WR}, {30'd0, MM_WR_NONE});
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK); #1;

        issue(LSU_SW, 32'h10, 32'h8899AABB); wait_done();
        issue(LSU_LW, 32'h10, 32'h0);        wait_done();
        preload(32'h20, 8'h80);
        preload(32'h21, 8'hFF);
        issue(LSU_LB, 32'h20, 32'h0);  wait_done();
        issue(LSU_LBU, 32'h20, 32'h0); wait_done();
        issue(LSU_LH, 32'h20, 32'h0);  wait_done();
        issue(LSU_LHU, 32'h20, 32'h0); wait_done();
        issue(LSU_LW, 32'h13, 32'h0);  wait_done();
        issue(LSU_LH, 32'h21, 32'h0);  wait_done();
        issue(LSU_SB, 32'h100, 32'h77); wait_done();
        issue(LSU_LW, 32'hFFFFFFFC, 32'h0); wait_done();
        issue(LSU_LW, 32'hFC, 32'h0);  wait_done();

        // Stray request while busy must be dropped.
        issue(LSU_SH, 32'h30, 32'h1234);
        REQ = 1'b1; OP = LSU_SB; ADDR = 32'h31; WDATA = 32'hEE;
        @(posedge CLK); #1;
        REQ = 1'b0;
        wait_done();
        issue(LSU_LHU, 32'h30, 32'h0); wait_done();

        // Reset during the store's issue cycle must suppress the write.
        preload(32'h40, 8'h00);
        REQ = 1'b1; OP = LSU_SB; ADDR = 32'h40; WDATA = 32'h55;
        @(posedge CLK); #1;
        REQ = 1'b0;
        RST = 1'b1;
        #1;
        chk("rst_mid_mm_wr", {30'd0, MM_WR}, {30'd0, MM_WR_NONE});
        chk("rst_mid_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_mid_done", {31'd0, DONE}, 32'd0);
        chk("rst_mid_rdata", RDATA, 32'd0);
        model_rdata = '0;
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK); #1;
        issue(LSU_LBU, 32'h40, 32'h0); wait_done();

        issue(LSU_SB, 32'h50, 32'hA5);  wait_done();
        issue(LSU_LBU, 32'h50, 32'h0);  wait_done();

        for (int k = 0; k < 200; k++) begin
            logic [2:0]  rop;
            logic [31:0] raddr;
            rop   = 3'($urandom_range(0, 7));
            raddr = ($urandom_range(0, 9) == 0) ? $urandom() : $urandom_range(0, 263);
            issue(rop, raddr, $urandom());
            wait_done();
        end

        repeat (4) @(posedge CLK);
        #1;
        chk("queue_drained", sb_q.size(), 32'd0);
        chk("write_count", wr_seen, wr_exp);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
